// File: rtl/evm_pkg.sv
// Shared types and constants for the voting machine: FSM states, candidate codes,
// default tally width and small decode helpers.
package evm_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StWaitRel
  } ballot_state_e;

  typedef logic [2:0] cand_code_t;

  localparam cand_code_t CandNone = 3'b000;
  localparam cand_code_t CandC1   = 3'b001;
  localparam cand_code_t CandC2   = 3'b010;
  localparam cand_code_t CandC3   = 3'b011;
  localparam cand_code_t CandC4   = 3'b100;
  // Winner logic reports a tie with this code.
  localparam cand_code_t CandTie  = 3'b111;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic cand_code_t btn_to_code(input logic [3:0] v);
    cand_code_t code;
    case (v)
      4'b0001: code = CandC1;
      4'b0010: code = CandC2;
      4'b0100: code = CandC3;
      4'b1000: code = CandC4;
      default: code = CandNone;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Increment-by-one counter that holds at its all-ones maximum; hit_o flags that the
// value about to be registered is the maximum.
module sat_counter
  import evm_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             hit_o
);

  localparam logic [WIDTH-1:0] Max = '1;

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != Max)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign hit_o   = (count_d == Max);

endmodule

// File: rtl/ballot_counter.sv
// Vote-capture unit: arms one ballot per officer issue, accepts one clean one-hot press,
// and keeps saturating per-candidate tallies plus a running total.
module ballot_counter
  import evm_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             ballot_en,
  input  logic [3:0]       btn,
  output logic [WIDTH-1:0] votecount1,
  output logic [WIDTH-1:0] votecount2,
  output logic [WIDTH-1:0] votecount3,
  output logic [WIDTH-1:0] votecount4,
  output logic [WIDTH+1:0] total,
  output logic             ballot_ready,
  output logic             vote_ack,
  output logic             invalid,
  output logic [2:0]       last_vote,
  output logic             sat
);

  ballot_state_e state_d, state_q;

  logic [3:0] btn_q;
  logic       ben_q;
  logic       ready_d, ready_q;
  logic       ack_d, ack_q;
  logic       inv_d, inv_q;
  cand_code_t last_d, last_q;
  logic       sat_d, sat_q;

  logic [3:0] press;
  logic       issue;
  logic       vote;
  logic [3:0] inc_vec;

  logic [WIDTH-1:0] tally [4];
  logic [3:0]       tally_hit;
  logic             total_hit;

  assign press = btn & ~btn_q;
  assign issue = ballot_en & ~ben_q;

  always_comb begin
    state_d = state_q;
    vote    = 1'b0;
    inv_d   = 1'b0;
    if (mode) begin
      // Result display discards any ballot in flight and ignores all presses.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (issue) state_d = StArmed;
        end
        StArmed: begin
          if (press != 4'd0) begin
            // One-hot test on the full level: a press while another button is held is rejected.
            if (is_onehot4(btn)) begin
              vote    = 1'b1;
              state_d = StWaitRel;
            end else begin
              inv_d = 1'b1;
            end
          end
        end
        StWaitRel: begin
          if (btn == 4'd0) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    inc_vec = vote ? btn : 4'd0;
    ack_d   = vote;
    ready_d = (state_d == StArmed);
    last_d  = vote ? btn_to_code(btn) : last_q;
    sat_d   = sat_q | (|tally_hit) | total_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      btn_q   <= 4'd0;
      ben_q   <= 1'b0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      inv_q   <= 1'b0;
      last_q  <= CandNone;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn;
      ben_q   <= ballot_en;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      inv_q   <= inv_d;
      last_q  <= last_d;
      sat_q   <= sat_d;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_tally
    sat_counter #(
      .WIDTH(WIDTH)
    ) u_tally (
      .clk_i  (clk),
      .rst_i  (rst),
      .inc_i  (inc_vec[i]),
      .count_o(tally[i]),
      .hit_o  (tally_hit[i])
    );
  end

  sat_counter #(
    .WIDTH(WIDTH + 2)
  ) u_total (
    .clk_i  (clk),
    .rst_i  (rst),
    .inc_i  (vote),
    .count_o(total),
    .hit_o  (total_hit)
  );

  assign votecount1   = tally[0];
  assign votecount2   = tally[1];
  assign votecount3   = tally[2];
  assign votecount4   = tally[3];
  assign ballot_ready = ready_q;
  assign vote_ack     = ack_q;
  assign invalid      = inv_q;
  assign last_vote    = last_q;
  assign sat          = sat_q;

endmodule
